// File: rtl/sensor_pulse_gen_if.sv
// Bundle of control, configuration and status signals for sensor_pulse_gen.
// Handshake: start is a one-cycle request, honoured only while the generator
// is idle; stop is a level that asks the running train to end after the
// pulse in flight. busy/done/pulses_sent report progress. dbg_state exposes
// the FSM encoding (0=IDLE, 1=HIGH, 2=LOW, 3=FIN).
interface sensor_pulse_gen_if #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [NUM_W-1:0] pulse_count;
  logic             sensor_out;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulses_sent;
  logic [1:0]       dbg_state;

  modport master (
    output start, stop, high_cycles, low_cycles, pulse_count,
    input  sensor_out, busy, done, pulses_sent, dbg_state
  );

  modport slave (
    input  start, stop, high_cycles, low_cycles, pulse_count,
    output sensor_out, busy, done, pulses_sent, dbg_state
  );
endinterface

// File: rtl/sensor_pulse_gen.sv
// Programmable pulse-train transmitter: N pulses of hi high cycles and lo
// low cycles (N=0 runs until stop). All outputs come straight from flops.
module sensor_pulse_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  sensor_pulse_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_hi;
  logic [CNT_W-1:0] r_lo;
  logic [NUM_W-1:0] r_n;
  logic [CNT_W-1:0] r_cnt;
  logic [NUM_W-1:0] r_pulses;
  logic             r_stop_pending;
  logic             r_out;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_hi_in;
  logic [CNT_W-1:0] w_lo_in;
  logic             w_last_pulse;

  // Zero-length phases are promoted to one cycle so the counter never underflows.
  assign w_hi_in = (bus.high_cycles == '0) ? CNT_W'(1) : bus.high_cycles;
  assign w_lo_in = (bus.low_cycles  == '0) ? CNT_W'(1) : bus.low_cycles;

  // The run ends after this pulse if a stop was seen or the fixed count is reached.
  assign w_last_pulse = r_stop_pending || bus.stop ||
                        ((r_n != '0) && (r_pulses == r_n));

  // Single FSM: phase sequencing, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_hi           <= CNT_W'(1);
      r_lo           <= CNT_W'(1);
      r_n            <= '0;
      r_cnt          <= '0;
      r_pulses       <= '0;
      r_stop_pending <= 1'b0;
      r_out          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done         <= 1'b0;
          r_stop_pending <= 1'b0;
          if (bus.start) begin
            r_hi     <= w_hi_in;
            r_lo     <= w_lo_in;
            r_n      <= bus.pulse_count;
            r_pulses <= '0;
            r_cnt    <= w_hi_in - CNT_W'(1);
            r_out    <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (bus.stop) r_stop_pending <= 1'b1;
          if (r_cnt == '0) begin
            r_pulses <= r_pulses + NUM_W'(1);
            r_cnt    <= r_lo - CNT_W'(1);
            r_out    <= 1'b0;
            r_state  <= S_LOW;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_LOW: begin
          if (bus.stop) r_stop_pending <= 1'b1;
          if (r_cnt == '0) begin
            if (w_last_pulse) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_cnt   <= r_hi - CNT_W'(1);
              r_out   <= 1'b1;
              r_state <= S_HIGH;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIN: begin
          r_done         <= 1'b0;
          r_stop_pending <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sensor_out  = r_out;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pulses_sent = r_pulses;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_sensor_pulse_gen.sv
// Directed bench for sensor_pulse_gen: a table of fixed-count runs checked
// cycle by cycle against an ideal waveform, plus hand-written sequences for
// stop, mid-run reset and counter wrap.
module tb_sensor_pulse_gen;

  localparam int CNT_W = 16;
  localparam int NUM_W = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sensor_pulse_gen_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

  sensor_pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    int n;
    bit poke;           // mid-run start + config change, must be ignored
    bit stop_at_start;  // stop together with start, must be ignored
    int exp_busy;       // hand-computed n*(hi'+lo')
    int exp_ps;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive a one-cycle start at the next negedge; returns at the negedge of
  // the first busy cycle.
  task automatic start_run(input int hi, input int lo, input int n, input bit with_stop);
    @(negedge clk);
    bus.high_cycles = CNT_W'(hi);
    bus.low_cycles  = CNT_W'(lo);
    bus.pulse_count = NUM_W'(n);
    bus.start       = 1'b1;
    bus.stop        = with_stop;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic run_fixed(input vec_t v);
    int hi_e;
    int lo_e;
    int per;
    hi_e = (v.hi == 0) ? 1 : v.hi;
    lo_e = (v.lo == 0) ? 1 : v.lo;
    per  = hi_e + lo_e;
    start_run(v.hi, v.lo, v.n, v.stop_at_start);
    for (int i = 0; i < v.exp_busy; i++) begin
      check("wave", 32'(bus.sensor_out), 32'(((i % per) < hi_e) ? 1 : 0));
      check("busy", 32'(bus.busy), 32'd1);
      if (v.poke && i == 5) begin
        bus.start       = 1'b1;
        bus.high_cycles = CNT_W'(9);
        bus.pulse_count = NUM_W'(1);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    check("fin_done", 32'(bus.done), 32'd1);
    check("fin_busy", 32'(bus.busy), 32'd0);
    check("fin_out", 32'(bus.sensor_out), 32'd0);
    check("fin_pulses", 32'(bus.pulses_sent), 32'(v.exp_ps));
    @(negedge clk);
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_state", 32'(bus.dbg_state), 32'd0);
    check("idle_pulses_hold", 32'(bus.pulses_sent), 32'(v.exp_ps));
  endtask

  // Continuous run; stop is raised during the first high cycle of pulse
  // stop_pulse (1-based) for one cycle.
  task automatic run_cont(input int hi, input int lo, input int stop_pulse, input int exp_ps);
    int  per;
    int  i;
    int  budget;
    bit  got_done;
    int  n_done;
    per      = hi + lo;
    budget   = stop_pulse * per + 20;
    got_done = 1'b0;
    n_done   = 0;
    i        = 0;
    start_run(hi, lo, 0, 1'b0);
    while (i < budget) begin
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      check("cont_wave", 32'(bus.sensor_out), 32'(((i % per) < hi) ? 1 : 0));
      check("cont_busy", 32'(bus.busy), 32'd1);
      bus.stop = ((i % per) == 0) && ((i / per + 1) == stop_pulse);
      @(negedge clk);
      i++;
    end
    bus.stop = 1'b0;
    check("cont_done_seen", 32'(got_done), 32'd1);
    check("cont_busy_len", 32'(i), 32'(stop_pulse * per));
    check("cont_pulses", 32'(bus.pulses_sent), 32'(exp_ps));
    if (got_done) n_done++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("cont_done_once", 32'(n_done), 32'd1);
    check("cont_idle_state", 32'(bus.dbg_state), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.high_cycles = '0;
    bus.low_cycles  = '0;
    bus.pulse_count = '0;

    vecs[0] = '{hi: 3,     lo: 2, n: 4,   poke: 1'b0, stop_at_start: 1'b0, exp_busy: 20,    exp_ps: 4};
    vecs[1] = '{hi: 0,     lo: 0, n: 3,   poke: 1'b0, stop_at_start: 1'b0, exp_busy: 6,     exp_ps: 3};
    vecs[2] = '{hi: 3,     lo: 2, n: 4,   poke: 1'b1, stop_at_start: 1'b0, exp_busy: 20,    exp_ps: 4};
    vecs[3] = '{hi: 1,     lo: 4, n: 2,   poke: 1'b0, stop_at_start: 1'b1, exp_busy: 10,    exp_ps: 2};
    vecs[4] = '{hi: 1,     lo: 1, n: 255, poke: 1'b0, stop_at_start: 1'b0, exp_busy: 510,   exp_ps: 255};
    vecs[5] = '{hi: 65535, lo: 1, n: 1,   poke: 1'b0, stop_at_start: 1'b0, exp_busy: 65536, exp_ps: 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out", 32'(bus.sensor_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_pulses", 32'(bus.pulses_sent), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);

    // stop while idle must not start anything
    @(negedge clk);
    bus.stop = 1'b1;
    repeat (3) @(negedge clk);
    bus.stop = 1'b0;
    check("idle_stop_busy", 32'(bus.busy), 32'd0);

    for (int v = 0; v < 6; v++) run_fixed(vecs[v]);

    // Continuous with stop in the 6th pulse's high phase
    run_cont(2, 2, 6, 6);

    // Mid-run reset during the 2nd pulse's high phase
    start_run(3, 2, 4, 1'b0);
    repeat (6) @(negedge clk);
    check("pre_rst_out", 32'(bus.sensor_out), 32'd1);
    check("pre_rst_pulses", 32'(bus.pulses_sent), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_out", 32'(bus.sensor_out), 32'd0);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_pulses", 32'(bus.pulses_sent), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (bus.done || bus.sensor_out || bus.busy) seen++;
      end
      check("mrst_quiet", 32'(seen), 32'd0);
    end
    run_fixed(vecs[0]);

    // Continuous wrap: 300 pulses of 1/1
    run_cont(1, 1, 300, 44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_pulse_gen.md
Name: sensor_pulse_gen

Overview:
Programmable pulse-train transmitter. It drives a sensor-style line with N pulses of configurable high time and low time, counted in clk cycles. It is the stimulus end of the sensor measurement path: it generates the waveform whose period and pulse count the sensor-side measurement block recovers. It is used in bench loopback and for on-board self-test.

Parameters:
CNT_W, 16, width of high/low phase length registers and phase counter
NUM_W, 8, width of pulse-count request and pulses_sent counter

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request; sampled only in IDLE
stop  input  1  level; request graceful termination (continuous mode or early abort)
high_cycles  input  CNT_W  high-phase length in clk cycles; 0 treated as 1
low_cycles  input  CNT_W  low-phase length in clk cycles; 0 treated as 1
pulse_count  input  NUM_W  number of pulses; 0 = continuous until stop
sensor_out  output  1  generated pulse line, registered (glitch-free)
busy  output  1  high from first HIGH cycle through last LOW cycle
done  output  1  one-cycle strobe after final pulse's low phase
pulses_sent  output  NUM_W  completed high phases in current/last run

Behaviour:
- Reset (rst=1 at an edge, any state): next cycle state=IDLE, sensor_out=0, busy=0, done=0, pulses_sent=0, phase counter=0. Reset during a pulse truncates it; no done is issued.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, HIGH, LOW, FIN.
- IDLE: sensor_out=0, busy=0. When start=1 at edge k:
  - latch hi=max(high_cycles,1), lo=max(low_cycles,1), n=pulse_count;
  - clear pulses_sent;
  - go to HIGH. From edge k, sensor_out=1 and busy=1 are visible in cycle k+1.
- Inputs are latched at start. Changes to high_cycles, low_cycles or pulse_count while busy have no effect on the run in progress.
- HIGH: sensor_out=1 for exactly hi cycles. On the last HIGH cycle, pulses_sent increments (NUM_W wrap-around in continuous mode) and the state goes to LOW.
- LOW: sensor_out=0 for exactly lo cycles. On the last LOW cycle:
  - if stop_pending=1, or (n!=0 and pulses_sent==n): go to FIN;
  - else go to HIGH.
- Resulting period = hi+lo cycles; duty = hi/(hi+lo).
- FIN: one cycle; done=1, busy=0, sensor_out=0. Then IDLE. pulses_sent holds its value until the next start or rst.
- stop handling:
  - stop sampled high in HIGH or LOW sets stop_pending. The current pulse completes both phases, then the run ends.
  - stop in IDLE or FIN is ignored; stop_pending clears on entry to IDLE.
  - stop and start in the same IDLE cycle: start wins, stop is ignored.
- start while busy (HIGH/LOW/FIN) is ignored and not queued.
- Phase counter counts down from hi-1 or lo-1 to 0. CNT_W max (65535) must work without overflow.
- Fixed-count runs: done occurs after exactly n*(hi+lo) busy cycles; the FIN cycle itself is the done cycle.

Test Plan:
- Basic run: high=3, low=2, count=4, start pulse → sensor_out = 4× (1,1,1,0,0) starting the cycle after start. busy high for 20 cycles, done at cycle 21, pulses_sent=4.
- Zero lengths: high=0, low=0, count=3 → alternating 1,0 for 6 cycles (treated as 1/1). Then done, pulses_sent=3.
- Continuous + stop: count=0, high=2, low=2; assert stop during the 6th pulse's high phase → that pulse completes its 2 low cycles, then done; pulses_sent=6.
- Ignored start / latched config: start again mid-run and change high_cycles to 9 → waveform unchanged, done after the original count.
- Mid-run reset: rst during a HIGH phase → sensor_out=0, busy=0, pulses_sent=0 next cycle, no done. A subsequent start runs normally.
- Wrap: count=0, high=1, low=1, run 300 pulses then stop → pulses_sent = 300 mod 256 = 44, done asserted once.
